bumpy_move_fsm: RTL
===================

BUMPY_MOVE_FSM -- requirements
Module: bumpy_move_fsm

Interface
REQ-001 Parameter JUMP_FRAMES, default 24: maximum number of frames spent in JUMP before a forced fall.
REQ-002 Parameter LIVES, default 3: lives loaded at reset.
REQ-003 Parameter RESPAWN_FRAMES, default 60: frames spent in RESPAWN before control returns.
REQ-004 Parameter KEY_W, default 4: key vector width, fixed order {down, right, up, left}, LSB = left.
REQ-005 clk  in  1  system clock.
REQ-006 resetN  in  1  asynchronous, active-low reset.
REQ-007 startOfFrame  in  1  one-clk pulse per video frame; the only counter time base.
REQ-008 key_n  in  KEY_W  active-low key levels (0 = pressed).
REQ-009 step_collision, free_collision, border_collision  in  1 each  single-clk collision pulses.
REQ-010 HitEdgeCode  in  4  edge hit {Left, Top, Right, Bottom}: BOTTOM=0001, RIGHT=0010, TOP=0100, LEFT=1000.
REQ-011 state  out  4  current state encoding.
REQ-012 lives_left  out  $clog2(LIVES+1)  remaining lives.
REQ-013 die  out  1  one-clk pulse on each life loss.
REQ-014 game_over  out  1  level, high in GAMEOVER.
REQ-015 jump_cnt  out  $clog2(JUMP_FRAMES+1)  frames elapsed in current jump.

Function
REQ-016 States SHALL be RESET, IDLE, LEFT, RIGHT, FALL, JUMP, DYING, RESPAWN, GAMEOVER; transitions are evaluated every clk, counters advance only on startOfFrame.
REQ-017 Landed condition: step_collision && HitEdgeCode==BOTTOM; landing key priority up > left > right > none, giving JUMP / LEFT / RIGHT / IDLE.
REQ-018 RESET: any key pressed -> FALL; otherwise hold.
REQ-019 IDLE: landed -> apply REQ-017; otherwise hold.
REQ-020 LEFT/RIGHT/FALL, in priority order:
- border_collision with BOTTOM -> DYING.
- border_collision with RIGHT while RIGHT -> LEFT.
- border_collision with LEFT while LEFT -> RIGHT.
- landed -> REQ-017.
- otherwise hold.
REQ-021 JUMP, in priority order:
- down key -> FALL.
- border_collision, or step_collision with TOP -> FALL.
- jump_cnt == JUMP_FRAMES -> FALL.
- free_collision with BOTTOM and left/right key -> LEFT/RIGHT.
- otherwise hold.
REQ-022 jump_cnt SHALL clear on JUMP entry, increment on each startOfFrame in JUMP, saturate at JUMP_FRAMES, and clear on exit.
REQ-023 DYING SHALL last exactly one clk: die=1, lives_left decrements; then -> RESPAWN if the new lives_left>0, else -> GAMEOVER.
REQ-024 RESPAWN SHALL load a frame counter with RESPAWN_FRAMES and decrement it on startOfFrame; at 0 -> RESET. Collisions are ignored in RESPAWN.
REQ-025 GAMEOVER is absorbing; only resetN exits it.
REQ-026 Simultaneous events on one clk SHALL resolve by the listed priority; startOfFrame coincident with a transition advances the counter of the state being left, then the entry clear wins.
REQ-027 lives_left SHALL never underflow; die never pulses in RESPAWN or GAMEOVER.
REQ-028 All outputs are registered or decoded directly from registered state; no combinational path from inputs to outputs.

Reset
REQ-029 On resetN low, regardless of mid-jump or mid-respawn: state=RESET, lives_left=LIVES, jump_cnt=0, respawn counter=0, die=0, game_over=0.
REQ-030 Reset assertion and deassertion SHALL take effect asynchronously; the first transition occurs on the first clk edge after deassertion.

Structure
REQ-031 The state enum, HitEdgeCode constants (BOTTOM/RIGHT/TOP/LEFT) and key index constants SHALL live in shared package bumpy_pkg.
REQ-032 The frame-tick down/up counter SHALL be one sub-module, frame_counter (parametrised width, load, enable, terminal flag), instantiated for jump and respawn timing.

Verification
REQ-033 Reset, press left -> FALL; landed pulse with no key -> IDLE; up key plus landed -> JUMP, jump_cnt=0.
REQ-034 JUMP_FRAMES=4, stay in JUMP, no collisions -> FALL on the clk after the 4th startOfFrame; jump_cnt returns to 0.
REQ-035 In RIGHT, border_collision with HitEdgeCode=0010 -> LEFT; same clk plus BOTTOM code -> DYING wins.
REQ-036 LIVES=2: two BOTTOM border hits -> die pulses twice, lives_left 2->1->0, GAMEOVER, game_over=1; keys ignored.
REQ-037 RESPAWN_FRAMES=3: after first death -> RESET after exactly 3 startOfFrame pulses; collisions in between have no effect.
REQ-038 resetN low mid-JUMP with jump_cnt=2 and lives_left=1 -> all outputs at reset values immediately.

Source files
------------

// File: rtl/bumpy_pkg.sv
// Shared types and constants for the bumpy character movement controller.
// States, edge-hit codes, key bit positions and the landing-priority helper.
package bumpy_pkg;

   typedef enum logic [3:0] {
      S_RESET    = 4'd0,
      S_IDLE     = 4'd1,
      S_LEFT     = 4'd2,
      S_RIGHT    = 4'd3,
      S_FALL     = 4'd4,
      S_JUMP     = 4'd5,
      S_DYING    = 4'd6,
      S_RESPAWN  = 4'd7,
      S_GAMEOVER = 4'd8
   } state_t;

   localparam logic [3:0] BOTTOM = 4'b0001;
   localparam logic [3:0] RIGHT  = 4'b0010;
   localparam logic [3:0] TOP    = 4'b0100;
   localparam logic [3:0] LEFT   = 4'b1000;

   localparam int KEY_LEFT  = 0;
   localparam int KEY_UP    = 1;
   localparam int KEY_RIGHT = 2;
   localparam int KEY_DOWN  = 3;

   // Where a landing goes: up beats left beats right, otherwise stand still.
   function automatic state_t landingState(input logic upKey, input logic leftKey,
                                           input logic rightKey);
      state_t target;
      target = S_IDLE;
      if (upKey) begin
         target = S_JUMP;
      end else if (leftKey) begin
         target = S_LEFT;
      end else if (rightKey) begin
         target = S_RIGHT;
      end
      return target;
   endfunction

endpackage

// File: rtl/frame_counter.sv
// Frame-tick counter that counts up or down between a load value and a terminal value.
// Load wins over enable; counting stops once the terminal value is reached.
module frame_counter #(
   parameter int WIDTH    = 4,
   parameter bit COUNT_UP = 1'b1
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             load,
   input  logic [WIDTH-1:0] loadValue,
   input  logic             enable,
   input  logic [WIDTH-1:0] terminalValue,
   output logic [WIDTH-1:0] count,
   output logic             terminal
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = loadValue;
      end else if (enable && !terminal) begin
         count_d = COUNT_UP ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign terminal = (count_q == terminalValue);
   assign count    = count_q;

endmodule

// File: rtl/bumpy_move_fsm.sv
// Movement/life controller for the bumpy character: walk, fall, jump, die, respawn.
// Outputs are the registered state, lives and jump counter, or direct decodes of them.
module bumpy_move_fsm
   import bumpy_pkg::*;
#(
   parameter int JUMP_FRAMES    = 24,
   parameter int LIVES          = 3,
   parameter int RESPAWN_FRAMES = 60,
   parameter int KEY_W          = 4
) (
   input  logic                             clk,
   input  logic                             resetN,
   input  logic                             startOfFrame,
   input  logic [KEY_W-1:0]                 key_n,
   input  logic                             step_collision,
   input  logic                             free_collision,
   input  logic                             border_collision,
   input  logic [3:0]                       HitEdgeCode,
   output logic [3:0]                       state,
   output logic [$clog2(LIVES+1)-1:0]       lives_left,
   output logic                             die,
   output logic                             game_over,
   output logic [$clog2(JUMP_FRAMES+1)-1:0] jump_cnt
);

   localparam int JW = $clog2(JUMP_FRAMES + 1);
   localparam int LW = $clog2(LIVES + 1);
   localparam int RW = $clog2(RESPAWN_FRAMES + 1);

   state_t          state_q;
   state_t          state_d;
   logic [LW-1:0]   lives_q;
   logic [LW-1:0]   lives_d;
   logic [JW-1:0]   jumpCount;
   logic            jumpAtLimit;
   logic [RW-1:0]   respawnCount;
   logic            respawnDone;

   logic keyLeft;
   logic keyUp;
   logic keyRight;
   logic keyDown;
   logic anyKey;
   logic landed;
   logic hitBottom;
   logic hitTop;
   logic hitRight;
   logic hitLeft;

   assign keyLeft   = ~key_n[KEY_LEFT];
   assign keyUp     = ~key_n[KEY_UP];
   assign keyRight  = ~key_n[KEY_RIGHT];
   assign keyDown   = ~key_n[KEY_DOWN];
   assign anyKey    = (key_n != {KEY_W{1'b1}});
   assign hitBottom = |(HitEdgeCode & BOTTOM);
   assign hitTop    = |(HitEdgeCode & TOP);
   assign hitRight  = |(HitEdgeCode & RIGHT);
   assign hitLeft   = |(HitEdgeCode & LEFT);
   assign landed    = step_collision && (HitEdgeCode == BOTTOM);

   // Each branch chain is written in event priority order, highest first.
   always_comb begin
      state_d = state_q;
      lives_d = lives_q;
      case (state_q)
         S_RESET: begin
            if (anyKey) begin
               state_d = S_FALL;
            end
         end
         S_IDLE: begin
            if (landed) begin
               state_d = landingState(keyUp, keyLeft, keyRight);
            end
         end
         S_LEFT, S_RIGHT, S_FALL: begin
            if (border_collision && hitBottom) begin
               state_d = S_DYING;
            end else if (border_collision && hitRight && (state_q == S_RIGHT)) begin
               state_d = S_LEFT;
            end else if (border_collision && hitLeft && (state_q == S_LEFT)) begin
               state_d = S_RIGHT;
            end else if (landed) begin
               state_d = landingState(keyUp, keyLeft, keyRight);
            end
         end
         S_JUMP: begin
            if (keyDown) begin
               state_d = S_FALL;
            end else if (border_collision || (step_collision && hitTop)) begin
               state_d = S_FALL;
            end else if (jumpAtLimit) begin
               state_d = S_FALL;
            end else if (free_collision && hitBottom && keyLeft) begin
               state_d = S_LEFT;
            end else if (free_collision && hitBottom && keyRight) begin
               state_d = S_RIGHT;
            end
         end
         S_DYING: begin
            if (lives_q != '0) begin
               lives_d = lives_q - LW'(1);
            end
            state_d = (lives_q > LW'(1)) ? S_RESPAWN : S_GAMEOVER;
         end
         S_RESPAWN: begin
            if (respawnDone) begin
               state_d = S_RESET;
            end
         end
         S_GAMEOVER: begin
            state_d = S_GAMEOVER;
         end
         default: begin
            state_d = S_RESET;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= S_RESET;
         lives_q <= LW'(LIVES);
      end else begin
         state_q <= state_d;
         lives_q <= lives_d;
      end
   end

   // Held at zero whenever the next state is not JUMP, so exit clears beat a coincident tick.
   frame_counter #(
      .WIDTH    (JW),
      .COUNT_UP (1'b1)
   ) jumpTimer (
      .clk           (clk),
      .resetN        (resetN),
      .load          (state_d != S_JUMP),
      .loadValue     ('0),
      .enable        (startOfFrame && (state_q == S_JUMP)),
      .terminalValue (JW'(JUMP_FRAMES)),
      .count         (jumpCount),
      .terminal      (jumpAtLimit)
   );

   frame_counter #(
      .WIDTH    (RW),
      .COUNT_UP (1'b0)
   ) respawnTimer (
      .clk           (clk),
      .resetN        (resetN),
      .load          ((state_q == S_DYING) && (state_d == S_RESPAWN)),
      .loadValue     (RW'(RESPAWN_FRAMES)),
      .enable        (startOfFrame && (state_q == S_RESPAWN)),
      .terminalValue ('0),
      .count         (respawnCount),
      .terminal      (respawnDone)
   );

   assign state      = state_q;
   assign lives_left = lives_q;
   assign die        = (state_q == S_DYING);
   assign game_over  = (state_q == S_GAMEOVER);
   assign jump_cnt   = jumpCount;

endmodule
